// File: rtl/glitch_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : glitch_pkg                                                    |
// | Purpose  : State encodings and default widths for the glitch sequencer.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package glitch_pkg;

    localparam int c_CNT_W     = 16;
    localparam int c_NUM_W     = 8;
    localparam int c_TRIG_SYNC = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/glitch_trig_sync.sv
// +--------------------------------------------------------------------------+
// | Module   : glitch_trig_sync                                              |
// | Purpose  : Trigger synchroniser with registered rising-edge detect.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module glitch_trig_sync #(
    parameter int TRIG_SYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_trigger,
    output logic o_trig_rise
);

    // Depths below two are not metastability-safe, so clamp them.
    localparam int c_DEPTH = (TRIG_SYNC < 2) ? 2 : TRIG_SYNC;

    logic [c_DEPTH-1:0] r_sync;
    logic               r_prev;
    logic               r_rise;

    // Edge flag is registered so it lands TRIG_SYNC cycles after the first sampling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[c_DEPTH-2:0], i_trigger};
            r_prev <= r_sync[c_DEPTH-1];
            r_rise <= r_sync[c_DEPTH-1] & ~r_prev;
        end
    end

    assign o_trig_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/glitch_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module   : glitch_sequencer                                              |
// | Purpose  : Trigger-synchronised glitch burst sequencer (delay/width/gap).|
// |            GLITCH_REARM_EN: DONE re-arms instead of returning to IDLE.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int CNT_W     = c_CNT_W,
    parameter int NUM_W     = c_NUM_W,
    parameter int TRIG_SYNC = c_TRIG_SYNC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [NUM_W-1:0] cfg_count,
    output logic             glitch_en,
    output logic             armed,
    output logic             busy,
    output logic             done,
    output logic [31:0]      pulse_total
);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [CNT_W-1:0]  r_delay, r_width, r_gap;
    logic [CNT_W-1:0]  w_width_m1, w_gap_m1;
    logic [NUM_W-1:0]  r_count, r_left, w_left_next;
    logic              w_trig_rise, w_pulse_entry, w_load_cfg;
    logic              r_glitch_en, r_armed, r_busy, r_done;
    logic [31:0]       r_pulse_total;

    glitch_trig_sync #(
        .TRIG_SYNC (TRIG_SYNC)
    ) u_trig_sync (
        .clk         (clk),
        .reset       (reset),
        .i_trigger   (trigger),
        .o_trig_rise (w_trig_rise)
    );

    // Zero-length width/gap behave as one cycle.
    assign w_width_m1 = (r_width == '0) ? '0 : r_width - CNT_W'(1);
    assign w_gap_m1   = (r_gap   == '0) ? '0 : r_gap   - CNT_W'(1);

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_left_next = r_left;
        w_load_cfg  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_load_cfg = 1'b1;
                    w_next     = (cfg_count == '0) ? ST_DONE : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_trig_rise) begin
                    w_left_next = r_count;
                    if (r_delay == '0) begin
                        w_next     = ST_PULSE;
                        w_cnt_next = w_width_m1;
                    end else begin
                        w_next     = ST_DELAY;
                        w_cnt_next = r_delay - CNT_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (r_cnt == '0) begin
                    w_next     = ST_PULSE;
                    w_cnt_next = w_width_m1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    if (r_left == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_GAP;
                        w_cnt_next = w_gap_m1;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_next     = ST_PULSE;
                    w_cnt_next = w_width_m1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
`ifdef GLITCH_REARM_EN
                w_next = (r_count == '0) ? ST_IDLE : ST_ARMED;
`else
                w_next = ST_IDLE;
`endif
            end
            default: w_next = ST_IDLE;
        endcase

        if (abort) begin
            w_next     = ST_IDLE;
            w_load_cfg = 1'b0;
        end

        w_pulse_entry = (w_next == ST_PULSE) && (r_state != ST_PULSE);
        if (w_pulse_entry) begin
            w_left_next = w_left_next - NUM_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_delay <= '0;
            r_width <= '0;
            r_gap   <= '0;
            r_count <= '0;
        end else if (w_load_cfg) begin
            r_delay <= cfg_delay;
            r_width <= cfg_width;
            r_gap   <= cfg_gap;
            r_count <= cfg_count;
        end
    end

    // Outputs are decoded from the next state so each one comes straight off a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_left        <= '0;
            r_glitch_en   <= 1'b0;
            r_armed       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pulse_total <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_left      <= w_left_next;
            r_glitch_en <= (w_next == ST_PULSE);
            r_armed     <= (w_next == ST_ARMED);
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_DONE);
            if (w_pulse_entry) begin
                r_pulse_total <= r_pulse_total + 32'd1;
            end
        end
    end

    assign glitch_en   = r_glitch_en;
    assign armed       = r_armed;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pulse_total = r_pulse_total;

endmodule

`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_glitch_sequencer                                           |
// | Purpose  : Directed self-checking bench for glitch_sequencer.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_glitch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        abort;
    logic        trigger;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_gap;
    logic [7:0]  cfg_count;
    logic        glitch_en;
    logic        armed;
    logic        busy;
    logic        done;
    logic [31:0] pulse_total;

    int total = 0;
    int bad   = 0;

    glitch_sequencer #(
        .CNT_W     (16),
        .NUM_W     (8),
        .TRIG_SYNC (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .abort       (abort),
        .trigger     (trigger),
        .cfg_delay   (cfg_delay),
        .cfg_width   (cfg_width),
        .cfg_gap     (cfg_gap),
        .cfg_count   (cfg_count),
        .glitch_en   (glitch_en),
        .armed       (armed),
        .busy        (busy),
        .done        (done),
        .pulse_total (pulse_total)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int d, input int w, input int g, input int c);
        cfg_delay = 16'(d);
        cfg_width = 16'(w);
        cfg_gap   = 16'(g);
        cfg_count = 8'(c);
    endtask

    task automatic do_arm(input int d, input int w, input int g, input int c);
        set_cfg(d, w, g, c);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Cycle i of the capture is the value just after edge i (edge 0 samples trigger high).
    task automatic capture(output logic [15:0] ge, output logic [15:0] dn, output logic [15:0] bz);
        ge = '0;
        dn = '0;
        bz = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ge[i] = glitch_en;
            dn[i] = done;
            bz[i] = busy;
        end
    endtask

    task automatic cleanup;
        trigger = 1'b0;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({glitch_en, armed, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {glitch_en, armed, busy, done});
        end
        total++;
        if (pulse_total !== 32'd0) begin
            bad++;
            $display("FAIL reset_total got=%0d want=0", pulse_total);
        end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic;
        logic [15:0] ge, dn, bz;
        logic        seen;
        do_arm(3, 2, 1, 2);
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("FAIL basic_armed got=%b want=1", armed);
        end
        trigger = 1'b1;
        capture(ge, dn, bz);
        total++;
        if (ge !== 16'h06C0) begin
            bad++;
            $display("FAIL basic_glitch got=%h want=06c0", ge);
        end
        total++;
        if (dn !== 16'h0800) begin
            bad++;
            $display("FAIL basic_done got=%h want=0800", dn);
        end
        total++;
        if (bz !== 16'h0FFF) begin
            bad++;
            $display("FAIL basic_busy got=%h want=0fff", bz);
        end
        total++;
        if (pulse_total !== 32'd2) begin
            bad++;
            $display("FAIL basic_total got=%0d want=2", pulse_total);
        end
`ifndef GLITCH_REARM_EN
        trigger = 1'b0;
        repeat (4) tick();
        trigger = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | glitch_en | busy;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL basic_single_shot got=%b want=0", seen);
        end
`endif
        cleanup();
    endtask

    task automatic test_zero_fields;
        logic [15:0] ge, dn, bz;
        do_arm(0, 0, 0, 3);
        trigger = 1'b1;
        capture(ge, dn, bz);
        total++;
        if (ge !== 16'h00A8) begin
            bad++;
            $display("FAIL zero_glitch got=%h want=00a8", ge);
        end
        total++;
        if (dn !== 16'h0100) begin
            bad++;
            $display("FAIL zero_done got=%h want=0100", dn);
        end
        total++;
        if (pulse_total !== 32'd5) begin
            bad++;
            $display("FAIL zero_total got=%0d want=5", pulse_total);
        end
        cleanup();
    endtask

    task automatic test_empty_burst;
        logic seen;
        do_arm(0, 1, 1, 0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL empty_done got=%b want=1", done);
        end
        tick();
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL empty_idle got=%b want=00", {done, busy});
        end
        trigger = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | glitch_en | busy;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL empty_no_activity got=%b want=0", seen);
        end
        total++;
        if (pulse_total !== 32'd5) begin
            bad++;
            $display("FAIL empty_total got=%0d want=5", pulse_total);
        end
        cleanup();
    endtask

    task automatic test_abort;
        logic seen;
        do_arm(0, 3, 2, 4);
        trigger = 1'b1;
        repeat (10) tick();
        total++;
        if (glitch_en !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_pulse got=%b want=1", glitch_en);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({glitch_en, busy, armed, done} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_outputs got=%b want=0000", {glitch_en, busy, armed, done});
        end
        total++;
        if (pulse_total !== 32'd7) begin
            bad++;
            $display("FAIL abort_total got=%0d want=7", pulse_total);
        end
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | glitch_en | busy | done;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_stays_idle got=%b want=0", seen);
        end
        cleanup();
    endtask

    task automatic test_held_trigger;
        logic seen;
        trigger = 1'b1;
        repeat (5) tick();
        do_arm(0, 1, 1, 1);
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | glitch_en;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL held_no_burst got=%b want=0", seen);
        end
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("FAIL held_still_armed got=%b want=1", armed);
        end
        cleanup();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL held_abort_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_arm_in_delay;
        logic [15:0] ge, dn;
        do_arm(5, 1, 1, 1);
        trigger = 1'b1;
        ge = '0;
        dn = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ge[i] = glitch_en;
            dn[i] = done;
            if (i == 4) begin
                set_cfg(0, 4, 1, 3);
                arm = 1'b1;
            end else if (i == 5) begin
                arm = 1'b0;
            end
        end
        total++;
        if (ge !== 16'h0100) begin
            bad++;
            $display("FAIL arm_delay_glitch got=%h want=0100", ge);
        end
        total++;
        if (dn !== 16'h0200) begin
            bad++;
            $display("FAIL arm_delay_done got=%h want=0200", dn);
        end
        total++;
        if (pulse_total !== 32'd8) begin
            bad++;
            $display("FAIL arm_delay_total got=%0d want=8", pulse_total);
        end
        cleanup();
    endtask

    task automatic test_reset_mid_pulse;
        do_arm(0, 5, 1, 1);
        trigger = 1'b1;
        repeat (5) tick();
        total++;
        if (glitch_en !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_in_pulse got=%b want=1", glitch_en);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({glitch_en, busy, armed, done} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b want=0000", {glitch_en, busy, armed, done});
        end
        total++;
        if (pulse_total !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_total got=%0d want=0", pulse_total);
        end
        trigger = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

`ifdef GLITCH_REARM_EN
    task automatic test_rearm;
        logic [15:0] ge, dn, bz;
        logic        lost;
        do_arm(2, 2, 1, 2);
        trigger = 1'b1;
        capture(ge, dn, bz);
        total++;
        if (ge !== 16'h0360) begin
            bad++;
            $display("FAIL rearm_glitch1 got=%h want=0360", ge);
        end
        total++;
        if (dn !== 16'h0400) begin
            bad++;
            $display("FAIL rearm_done1 got=%h want=0400", dn);
        end
        trigger = 1'b0;
        lost = 1'b0;
        repeat (34) begin
            tick();
            if (!armed || glitch_en) lost = 1'b1;
        end
        total++;
        if (lost !== 1'b0) begin
            bad++;
            $display("FAIL rearm_armed_between got=%b want=0", lost);
        end
        trigger = 1'b1;
        capture(ge, dn, bz);
        total++;
        if (ge !== 16'h0360) begin
            bad++;
            $display("FAIL rearm_glitch2 got=%h want=0360", ge);
        end
        total++;
        if (dn !== 16'h0400) begin
            bad++;
            $display("FAIL rearm_done2 got=%h want=0400", dn);
        end
        cleanup();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rearm_abort_idle got=%b want=0", busy);
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        arm     = 1'b0;
        abort   = 1'b0;
        trigger = 1'b0;
        set_cfg(0, 0, 0, 0);
        test_reset();
        test_basic();
        test_zero_fields();
        test_empty_burst();
        test_abort();
        test_held_trigger();
        test_arm_in_delay();
        test_reset_mid_pulse();
`ifdef GLITCH_REARM_EN
        test_rearm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
